fpu_rr_scheduler: RTL and testbench

Shares one adder/subtractor FPU core (custom 32-bit format: sign[31], 6-bit exponent[30:25] with bias 31, 25-bit mantissa[24:0]) between N_REQ requesters.
- Round-robin arbitration, valid/ready request capture and operand holding.
- Issues a start pulse to the core and waits for its done pulse, with a watchdog timeout.
- Returns result, status and requester ID over a valid/ready response channel.
- Sits between the client blocks and the FPU core; one operation in flight at a time.

---
 rtl/fpu_rr_scheduler.sv | 99 +++++++++
 tb/tb_fpu_rr_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler: round-robin arbiter sharing one FPU add/sub core among N_REQ requesters
module fpu_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_op_a,
  input  logic [32*N_REQ-1:0]  req_op_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_data,
  output logic [3:0]           resp_status,
  output logic                 fpu_start,
  output logic [31:0]          fpu_op_a,
  output logic [31:0]          fpu_op_b,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_result,
  input  logic [3:0]           fpu_status,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, idx;
  logic found;
  logic [7:0] tmo_cnt;
  logic tmo_hit;
  assign tmo_hit    = tmo_cnt == 8'(TIMEOUT - 2);
  assign req_ready  = (state == IDLE && found) ? N_REQ'(1) << grant : '0;
  assign resp_valid = state == RESP;
  assign fpu_start  = state == ISSUE;
  assign busy       = state != IDLE;
  // first valid requester at or after rr_ptr; scanning downward lets the nearest one win
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  // next-state logic; a done pulse in the timeout cycle still counts as done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = found ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = (fpu_done || tmo_hit) ? RESP : WAIT;
      RESP:    state_nxt = resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // state register, operand capture, result capture, pointer and counter updates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      resp_id     <= '0;
      resp_data   <= '0;
      resp_status <= '0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      op_count    <= '0;
      tmo_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        fpu_op_a <= req_op_a[32*int'(grant) +: 32];
        fpu_op_b <= req_op_b[32*int'(grant) +: 32];
        resp_id  <= grant;
      end
      if (state == ISSUE) tmo_cnt <= '0;
      if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
        if (fpu_done) begin
          resp_data   <= fpu_result;
          resp_status <= fpu_status;
        end else if (tmo_hit) begin
          resp_data   <= '0;
          resp_status <= 4'b1000;
        end
      end
      if (state == RESP && resp_ready) begin
        rr_ptr   <= (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + 1'b1;
        op_count <= op_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// tb_fpu_rr_scheduler: directed and random checks of the round-robin FPU scheduler against a transaction model
module tb_fpu_rr_scheduler;
  localparam int N = 4, IDW = 2, TO = 16, CW = 4;
  logic clock, reset;
  logic [N-1:0] req_valid, req_ready;
  logic [32*N-1:0] req_op_a, req_op_b;
  logic resp_valid, resp_ready;
  logic [IDW-1:0] resp_id;
  logic [31:0] resp_data, fpu_op_a, fpu_op_b, fpu_result;
  logic [3:0] resp_status, fpu_status;
  logic fpu_start, fpu_done, busy;
  logic [CW-1:0] op_count;

  fpu_rr_scheduler #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_status(resp_status), .fpu_start(fpu_start),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .fpu_status(fpu_status), .busy(busy), .op_count(op_count));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks, errors, ptr, cnt_m, acc, cyc, lat, op_lat, exp_id, first;
  bit outst, hold;
  logic [31:0] exp_a, exp_b, last_data, sa, sb;
  logic [3:0] last_status;
  int glog[$];

  function automatic logic [31:0] core_res(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h3E000000 && b == 32'h3E000000) ? 32'h40000000 : a + b;
  endfunction
  function automatic logic [3:0] core_st(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h3E000000 && b == 32'h3E000000) ? 4'b0001 : {1'b0, a[2:0] ^ b[2:0]};
  endfunction

  // behavioural core: done pulse lat cycles after the start pulse, cleared by reset
  initial begin
    int cc;
    cc = 0;
    fpu_done = 1'b0;
    fpu_result = '0;
    fpu_status = '0;
    forever begin
      @(negedge clock);
      fpu_done = 1'b0;
      if (!reset) cc = 0;
      if (cc > 0) begin
        cc--;
        if (cc == 0) begin
          fpu_done = 1'b1;
          fpu_result = core_res(fpu_op_a, fpu_op_b);
          fpu_status = core_st(fpu_op_a, fpu_op_b);
        end
      end
      if (fpu_start) cc = lat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_checks();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_status", 32'(resp_status), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fpu_op_a", fpu_op_a, 32'd0);
    chk("rst_fpu_op_b", fpu_op_b, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
  endtask

  // one clock: predict grant/handshakes from the model, then check registered outputs
  task automatic step();
    bit found, acc_now;
    int g, dly;
    #1;
    found = 0;
    g = 0;
    acc_now = 0;
    for (int k = 0; k < N; k++)
      if (!found && req_valid[(ptr + k) % N]) begin
        found = 1;
        g = (ptr + k) % N;
      end
    chk("req_ready", 32'(req_ready), (!outst && found) ? 32'd1 << g : 32'd0);
    dly = (op_lat >= TO) ? TO + 1 : op_lat + 2;
    if (!outst && found) begin
      outst = 1;
      acc_now = 1;
      acc = cyc;
      exp_id = g;
      op_lat = lat;
      exp_a = req_op_a[32*g +: 32];
      exp_b = req_op_b[32*g +: 32];
      glog.push_back(g);
    end else if (outst && cyc - acc >= dly && resp_ready) begin
      outst = 0;
      ptr = (exp_id + 1) % N;
      cnt_m++;
      last_data = resp_data;
      last_status = resp_status;
    end
    dly = (op_lat >= TO) ? TO + 1 : op_lat + 2;
    @(negedge clock);
    cyc++;
    chk("busy", 32'(busy), 32'(outst));
    chk("op_count", 32'(op_count), 32'(cnt_m % (1 << CW)));
    chk("fpu_start", 32'(fpu_start), 32'(outst && cyc - acc == 1));
    chk("resp_valid", 32'(resp_valid), 32'(outst && cyc - acc >= dly));
    if (outst && cyc - acc == 1) begin
      chk("fpu_op_a", fpu_op_a, exp_a);
      chk("fpu_op_b", fpu_op_b, exp_b);
    end
    if (outst && cyc - acc >= dly) begin
      chk("resp_id", 32'(resp_id), 32'(exp_id));
      chk("resp_data", resp_data, op_lat >= TO ? 32'd0 : core_res(exp_a, exp_b));
      chk("resp_status", 32'(resp_status), 32'(op_lat >= TO ? 4'b1000 : core_st(exp_a, exp_b)));
    end
    if (acc_now) begin
      if (hold) begin
        req_op_a[32*g +: 32] = $urandom();
        req_op_b[32*g +: 32] = $urandom();
      end else req_valid[g] = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((outst || req_valid != '0) && t < 100) begin
      step();
      t++;
    end
    chk("drain_bound", 32'(outst), 32'd0);
    repeat (2) step();
  endtask

  task automatic rand_step();
    for (int i = 0; i < N; i++)
      if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_op_a[32*i +: 32] = $urandom();
        req_op_b[32*i +: 32] = $urandom();
      end else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
    resp_ready = $urandom_range(0, 2) != 0;
    if (!outst) lat = $urandom_range(1, TO - 1);
    step();
  endtask

  initial begin
    checks = 0; errors = 0; ptr = 0; cnt_m = 0; acc = 0; cyc = 0; lat = 5; op_lat = 5;
    exp_id = 0; outst = 0; hold = 0; last_data = '0; last_status = '0;
    reset = 1'b0; resp_ready = 1'b0; req_valid = '0; req_op_a = '0; req_op_b = '0;
    #3;
    zero_checks();
    @(negedge clock);
    reset = 1'b1;
    // fairness: everyone requesting continuously
    lat = 2; hold = 1; resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_op_a[32*i +: 32] = $urandom();
      req_op_b[32*i +: 32] = $urandom();
    end
    req_valid = '1;
    glog.delete();
    first = ptr;
    for (int t = 0; t < 60 && glog.size() < 5; t++) step();
    hold = 0;
    req_valid = '0;
    drain();
    chk("fair_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("fair_order", 32'(glog[i]), 32'((first + i) % N));
    // single op 1.0 + 1.0
    lat = 5;
    req_op_a[31:0] = 32'h3E000000;
    req_op_b[31:0] = 32'h3E000000;
    req_valid = 4'b0001;
    drain();
    chk("single_data", last_data, 32'h40000000);
    chk("single_status", 32'(last_status), 32'd1);
    chk("single_count", 32'(op_count), 32'd6);
    // back-pressure with another requester waiting
    lat = 3; resp_ready = 1'b0;
    req_op_a[95:64] = $urandom();
    req_op_b[95:64] = $urandom();
    req_valid = 4'b0100;
    for (int t = 0; t < 30 && !(outst && cyc - acc >= op_lat + 2); t++) step();
    req_op_a[127:96] = $urandom();
    req_op_b[127:96] = $urandom();
    req_valid[3] = 1'b1;
    repeat (10) step();
    resp_ready = 1'b1;
    drain();
    chk("bp_next_grant", 32'(glog[$]), 32'd3);
    // timeout followed by a late done pulse
    lat = TO + 5;
    req_op_a[31:0] = $urandom();
    req_op_b[31:0] = $urandom();
    req_valid = 4'b0001;
    drain();
    repeat (8) step();
    chk("tmo_data", last_data, 32'd0);
    chk("tmo_status", 32'(last_status), 32'd8);
    // done arriving in the same cycle as the timeout wins
    lat = TO - 1;
    sa = $urandom();
    sb = $urandom();
    req_op_a[63:32] = sa;
    req_op_b[63:32] = sb;
    req_valid = 4'b0010;
    drain();
    chk("tie_data", last_data, core_res(sa, sb));
    chk("tie_status", 32'(last_status), 32'(core_st(sa, sb)));
    // reset in the middle of WAIT
    lat = 20;
    req_op_a[63:32] = $urandom();
    req_op_b[63:32] = $urandom();
    req_valid = 4'b0010;
    repeat (6) step();
    reset = 1'b0;
    #2;
    zero_checks();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    outst = 0; ptr = 0; cnt_m = 0; req_valid = '0;
    lat = 4;
    req_op_a[31:0] = $urandom();
    req_op_a[127:96] = $urandom();
    req_valid = 4'b1001;
    glog.delete();
    drain();
    chk("rst_first_grant", 32'(glog[0]), 32'd0);
    // random traffic until the counter wraps
    for (int t = 0; t < 4000 && cnt_m < 17; t++) rand_step();
    chk("wrap", 32'(op_count), 32'd1);
    req_valid = '0;
    resp_ready = 1'b1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
